// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus: redirect/control inputs from the pipeline, fetch address and status back out.
interface pc_unit_if #(parameter int NB_ADDR = 32);
   logic               i_stall;
   logic               i_halt;
   logic               i_exc_valid;
   logic               i_branch_valid;
   logic [NB_ADDR-1:0] i_branch_addr;
   logic               i_jump_valid;
   logic [NB_ADDR-1:0] i_jump_addr;
   logic               i_call;
   logic [NB_ADDR-1:0] i_jump_ret;
   logic               i_ret;
   logic [NB_ADDR-1:0] o_pc;
   logic [NB_ADDR-1:0] o_pc_seq;
   logic               o_valid;
   logic               o_redirect;
   logic               o_ras_empty;

   modport master (
      output i_stall, i_halt, i_exc_valid, i_branch_valid, i_branch_addr,
             i_jump_valid, i_jump_addr, i_call, i_jump_ret, i_ret,
      input  o_pc, o_pc_seq, o_valid, o_redirect, o_ras_empty
   );

   modport slave (
      input  i_stall, i_halt, i_exc_valid, i_branch_valid, i_branch_addr,
             i_jump_valid, i_jump_addr, i_call, i_jump_ret, i_ret,
      output o_pc, o_pc_seq, o_valid, o_redirect, o_ras_empty
   );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: exc > branch > jump > pending > sequential next-PC select,
// stall-held redirects and HALT. Define PC_RAS_EN for the circular return-address stack.
module pc_unit #(
   parameter int                 NB_ADDR      = 32,
   parameter int                 INC          = 4,
   parameter logic [NB_ADDR-1:0] RESET_VECTOR = '0,
   parameter logic [NB_ADDR-1:0] EXC_VECTOR   = 'h80,
   parameter int                 RAS_DEPTH    = 4
) (
   input  logic     i_clk,
   input  logic     i_reset,
   pc_unit_if.slave bus
);
   localparam logic [NB_ADDR-1:0] ALIGN_MASK = ~NB_ADDR'(INC - 1);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

   typedef struct packed {
      logic               vld;
      logic               is_br;
      logic [NB_ADDR-1:0] addr;
   } pend_t;

   state_t             state_q, state_d;
   pend_t              pend_q, pend_d;
   logic [NB_ADDR-1:0] pc_q, pc_d, pc_seq, br_tgt, jmp_tgt, ras_top;
   logic               valid_q, valid_d, redir_q, redir_d;
   logic               jump_take, ras_empty;

   assign pc_seq  = pc_q + NB_ADDR'(INC);
   assign br_tgt  = bus.i_branch_addr & ALIGN_MASK;
   assign jmp_tgt = ((bus.i_ret && !ras_empty) ? ras_top : bus.i_jump_addr) & ALIGN_MASK;

   always_ff @(negedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         redir_q <= 1'b0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         redir_q <= redir_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = valid_q;
      redir_d   = 1'b0;
      pend_d    = pend_q;
      jump_take = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            valid_d = 1'b1;
         end
         ST_RUN: begin
            if (bus.i_exc_valid) begin
               pc_d    = EXC_VECTOR;
               pend_d  = '0;
               redir_d = 1'b1;
            end else if (bus.i_stall) begin
               // A jump may not displace a held branch; anything else replaces the entry.
               if (bus.i_branch_valid)
                  pend_d = '{vld: 1'b1, is_br: 1'b1, addr: br_tgt};
               else if (bus.i_jump_valid && !(pend_q.vld && pend_q.is_br))
                  pend_d = '{vld: 1'b1, is_br: 1'b0, addr: jmp_tgt};
            end else if (bus.i_halt) begin
               state_d = ST_HALT;
               valid_d = 1'b0;
            end else begin
               pend_d  = '0;
               redir_d = 1'b1;
               if (bus.i_branch_valid) begin
                  pc_d = br_tgt;
               end else if (bus.i_jump_valid) begin
                  pc_d      = jmp_tgt;
                  jump_take = 1'b1;
               end else if (pend_q.vld) begin
                  pc_d = pend_q.addr;
               end else begin
                  pc_d    = pc_seq;
                  redir_d = 1'b0;
               end
            end
         end
         ST_HALT: begin
            if (bus.i_exc_valid) begin
               state_d = ST_RUN;
               valid_d = 1'b1;
               pc_d    = EXC_VECTOR;
               pend_d  = '0;
               redir_d = 1'b1;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

`ifdef PC_RAS_EN
   localparam int             PW       = $clog2(RAS_DEPTH);
   localparam logic [PW:0]    RAS_FULL = RAS_DEPTH[PW:0];

   logic [NB_ADDR-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]      ras_ptr_q, ras_ptr_d;
   logic [PW:0]        ras_cnt_q, ras_cnt_d;
   logic               ras_push, ras_pop;

   assign ras_empty = (ras_cnt_q == '0);
   assign ras_top   = ras_mem[ras_ptr_q];
   // Only a jump that actually redirects fetch touches the stack.
   assign ras_pop   = jump_take && bus.i_ret && !ras_empty;
   assign ras_push  = jump_take && bus.i_call && !bus.i_ret;

   always_comb begin
      ras_ptr_d = ras_ptr_q;
      ras_cnt_d = ras_cnt_q;
      if (ras_pop) begin
         ras_ptr_d = ras_ptr_q - PW'(1);
         ras_cnt_d = ras_cnt_q - (PW+1)'(1);
      end else if (ras_push) begin
         ras_ptr_d = ras_ptr_q + PW'(1);
         if (ras_cnt_q != RAS_FULL)
            ras_cnt_d = ras_cnt_q + (PW+1)'(1);
      end
   end

   always_ff @(negedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   // Wrapping pointer overwrites the oldest entry once the stack is full.
   always_ff @(negedge i_clk) begin
      if (ras_push)
         ras_mem[ras_ptr_d] <= bus.i_jump_ret;
   end
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic unused_ras;

   assign ras_empty  = 1'b1;
   assign ras_top    = bus.i_jump_addr;
   assign unused_ras = ^{bus.i_call, bus.i_jump_ret, jump_take};
`endif

   assign bus.o_pc        = pc_q;
   assign bus.o_pc_seq    = pc_seq;
   assign bus.o_valid     = valid_q;
   assign bus.o_redirect  = redir_q;
   assign bus.o_ras_empty = ras_empty;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand sequences for halt/reset/RAS, random vs. model.
`timescale 1ns/1ps
module tb_pc_unit;
   localparam int          INC   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] EXC   = 32'h80;
   localparam logic [31:0] MASK  = ~32'(INC - 1);
`ifdef PC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic clk = 1'b1;
   logic rst_n = 1'b0;
   logic rst8_n = 1'b0;
   always #5 clk = ~clk;

   pc_unit_if #(.NB_ADDR(32)) bus ();
   pc_unit_if #(.NB_ADDR(8))  bus8 ();

   pc_unit #(.NB_ADDR(32), .INC(INC), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .RAS_DEPTH(DEPTH))
      u_dut (.i_clk(clk), .i_reset(rst_n), .bus(bus.slave));
   pc_unit #(.NB_ADDR(8), .INC(4), .RESET_VECTOR(8'hFC), .EXC_VECTOR(8'h80), .RAS_DEPTH(2))
      u_dut8 (.i_clk(clk), .i_reset(rst8_n), .bus(bus8.slave));

   typedef struct {
      string       nm;
      bit          stall, halt, exc, br;
      logic [31:0] ba;
      bit          jmp;
      logic [31:0] ja;
      bit          call, ret;
      logic [31:0] jr;
      logic [31:0] e_pc;
      bit          e_valid, e_redir;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   function automatic vec_t mk(string nm, bit st, bit hl, bit ex, bit br, logic [31:0] ba,
                               bit jp, logic [31:0] ja, logic [31:0] epc, bit ev, bit er);
      vec_t v;
      v.nm = nm; v.stall = st; v.halt = hl; v.exc = ex; v.br = br; v.ba = ba;
      v.jmp = jp; v.ja = ja; v.call = 0; v.ret = 0; v.jr = 0;
      v.e_pc = epc; v.e_valid = ev; v.e_redir = er;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.i_stall = v.stall;     bus.i_halt = v.halt;       bus.i_exc_valid = v.exc;
      bus.i_branch_valid = v.br; bus.i_branch_addr = v.ba;
      bus.i_jump_valid = v.jmp;  bus.i_jump_addr = v.ja;
      bus.i_call = v.call;       bus.i_ret = v.ret;         bus.i_jump_ret = v.jr;
   endtask

   // DUT updates on the falling edge; outputs are sampled just after the rising edge.
   task automatic edge_step();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic check_vec(vec_t v);
      chk({v.nm, ".pc"}, bus.o_pc, v.e_pc);
      chk({v.nm, ".pc_seq"}, bus.o_pc_seq, v.e_pc + INC);
      chk({v.nm, ".valid"}, 32'(bus.o_valid), 32'(v.e_valid));
      chk({v.nm, ".redirect"}, 32'(bus.o_redirect), 32'(v.e_redir));
   endtask

   // Reference model: spec rules over plain variables, RAS as a bounded queue.
   bit          m_booted, m_halted, m_valid, m_redir, p_vld;
   int          p_prio;
   logic [31:0] m_pc, p_addr;
   logic [31:0] ras_q[$];

   task automatic model_reset();
      m_booted = 0; m_halted = 0; m_valid = 0; m_redir = 0;
      p_vld = 0; p_prio = 0; p_addr = 0; m_pc = 0;
      ras_q.delete();
   endtask

   task automatic model_edge(vec_t v);
      logic [31:0] jt;
      bit had_pend;
      m_redir = 0;
      if (!m_booted) begin m_booted = 1; m_valid = 1; return; end
      if (m_halted) begin
         if (v.exc) begin m_halted = 0; m_valid = 1; m_pc = EXC; m_redir = 1; p_vld = 0; end
         return;
      end
      if (v.exc) begin m_pc = EXC; m_redir = 1; p_vld = 0; return; end
      jt = (RAS_EN && v.ret && ras_q.size() > 0) ? ras_q[ras_q.size()-1] : v.ja;
      jt = jt & MASK;
      if (v.stall) begin
         if (v.br) begin p_vld = 1; p_prio = 2; p_addr = v.ba & MASK; end
         else if (v.jmp && (!p_vld || p_prio <= 1)) begin p_vld = 1; p_prio = 1; p_addr = jt; end
         return;
      end
      if (v.halt) begin m_halted = 1; m_valid = 0; return; end
      had_pend = p_vld; p_vld = 0; m_redir = 1;
      if (v.br) m_pc = v.ba & MASK;
      else if (v.jmp) begin
         m_pc = jt;
         if (RAS_EN) begin
            if (v.ret) begin
               if (ras_q.size() > 0) void'(ras_q.pop_back());
            end else if (v.call) begin
               ras_q.push_back(v.jr);
               if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
         end
      end else if (had_pend) m_pc = p_addr;
      else begin m_pc = m_pc + INC; m_redir = 0; end
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      vec_t idle;
      bit   do_rst;

      idle = mk("idle", 0,0,0,0,0, 0,0, 0,0,0);
      drive(idle);
      bus8.i_stall = 0; bus8.i_halt = 0; bus8.i_exc_valid = 0; bus8.i_branch_valid = 0;
      bus8.i_branch_addr = 0; bus8.i_jump_valid = 0; bus8.i_jump_addr = 0;
      bus8.i_call = 0; bus8.i_ret = 0; bus8.i_jump_ret = 0;
      #12;

      chk("rst.pc", bus.o_pc, 32'h0);
      chk("rst.valid", 32'(bus.o_valid), 0);
      chk("rst.redirect", 32'(bus.o_redirect), 0);
      chk("rst.ras_empty", 32'(bus.o_ras_empty), 1);
      chk("rst8.pc", 32'(bus8.o_pc), 32'hFC);
      chk("rst8.pc_seq_wrap", 32'(bus8.o_pc_seq), 32'h00);

      // 8-bit PC wrap while the main DUT stays held in reset
      rst8_n = 1'b1;
      edge_step();
      chk("w8.boot_pc", 32'(bus8.o_pc), 32'hFC);
      chk("w8.boot_valid", 32'(bus8.o_valid), 1);
      edge_step();
      chk("w8.wrap_pc", 32'(bus8.o_pc), 32'h00);
      chk("w8.wrap_redirect", 32'(bus8.o_redirect), 0);
      chk("held_rst.pc", bus.o_pc, 32'h0);
      chk("held_rst.valid", 32'(bus.o_valid), 0);

      rst_n = 1'b1;
      //                   name        st hl ex br ba           jp ja           pc           v  r
      tbl.push_back(mk("boot",       0,0,0,0,32'h0,      0,32'h0,      32'h0,       1,0));
      tbl.push_back(mk("seq1",       0,0,0,0,32'h0,      0,32'h0,      32'h4,       1,0));
      tbl.push_back(mk("seq2",       0,0,0,0,32'h0,      0,32'h0,      32'h8,       1,0));
      tbl.push_back(mk("seq3",       0,0,0,0,32'h0,      0,32'h0,      32'hC,       1,0));
      tbl.push_back(mk("stl_jmp",    1,0,0,0,32'h0,      1,32'h40,     32'hC,       1,0));
      tbl.push_back(mk("stl2",       1,0,0,0,32'h0,      0,32'h0,      32'hC,       1,0));
      tbl.push_back(mk("stl3",       1,0,0,0,32'h0,      0,32'h0,      32'hC,       1,0));
      tbl.push_back(mk("pend_load",  0,0,0,0,32'h0,      0,32'h0,      32'h40,      1,1));
      tbl.push_back(mk("after_pend", 0,0,0,0,32'h0,      0,32'h0,      32'h44,      1,0));
      tbl.push_back(mk("br_vs_jmp",  0,0,0,1,32'h100,    1,32'h200,    32'h100,     1,1));
      tbl.push_back(mk("stl_exc",    1,0,1,0,32'h0,      0,32'h0,      EXC,         1,1));
      tbl.push_back(mk("post_exc",   0,0,0,0,32'h0,      0,32'h0,      32'h84,      1,0));
      tbl.push_back(mk("stl_br",     1,0,0,1,32'h300,    0,32'h0,      32'h84,      1,0));
      tbl.push_back(mk("stl_jlow",   1,0,0,0,32'h0,      1,32'h400,    32'h84,      1,0));
      tbl.push_back(mk("br_kept",    0,0,0,0,32'h0,      0,32'h0,      32'h300,     1,1));
      tbl.push_back(mk("stl_j500",   1,0,0,0,32'h0,      1,32'h500,    32'h300,     1,0));
      tbl.push_back(mk("stl_j600",   1,0,0,0,32'h0,      1,32'h600,    32'h300,     1,0));
      tbl.push_back(mk("j_overwr",   0,0,0,0,32'h0,      0,32'h0,      32'h600,     1,1));
      tbl.push_back(mk("br_align",   0,0,0,1,32'h203,    0,32'h0,      32'h200,     1,1));
      tbl.push_back(mk("stl_j700",   1,0,0,0,32'h0,      1,32'h700,    32'h200,     1,0));
      tbl.push_back(mk("exc_clr",    1,0,1,0,32'h0,      0,32'h0,      EXC,         1,1));
      tbl.push_back(mk("no_pend",    0,0,0,0,32'h0,      0,32'h0,      32'h84,      1,0));
      tbl.push_back(mk("halt_stl",   1,1,0,0,32'h0,      0,32'h0,      32'h84,      1,0));
      tbl.push_back(mk("halt",       0,1,0,0,32'h0,      0,32'h0,      32'h84,      0,0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         edge_step();
         check_vec(tbl[i]);
      end

      // HALT freezes fetch even with branches/jumps offered
      for (int k = 0; k < 10; k++) begin
         v = mk("halt_frz", 0,0,0,1,32'h100, 1,32'h200, 32'h84,0,0);
         drive(v); edge_step(); check_vec(v);
      end
      v = mk("halt_exc", 0,0,1,0,32'h0, 0,32'h0, EXC,1,1);
      drive(v); edge_step(); check_vec(v);

      // Reset mid-operation discards a held redirect
      v = mk("pre_rst", 1,0,0,0,32'h0, 1,32'h900, EXC,1,0);
      drive(v); edge_step(); check_vec(v);
      rst_n = 1'b0;
      #1;
      chk("midrst.pc", bus.o_pc, 32'h0);
      chk("midrst.valid", 32'(bus.o_valid), 0);
      chk("midrst.redirect", 32'(bus.o_redirect), 0);
      chk("midrst.ras_empty", 32'(bus.o_ras_empty), 1);
      drive(idle); edge_step();
      rst_n = 1'b1;
      v = mk("rst_boot", 0,0,0,0,32'h0, 0,32'h0, 32'h0,1,0);
      drive(v); edge_step(); check_vec(v);
      v = mk("rst_nopend", 0,0,0,0,32'h0, 0,32'h0, 32'h4,1,0);
      drive(v); edge_step(); check_vec(v);

      // Five calls into a 4-deep stack, then five returns
      for (int k = 0; k < 5; k++) begin
         v = mk("call", 0,0,0,0,32'h0, 1,32'h1000 + 32'h100*k, 32'h1000 + 32'h100*k,1,1);
         v.call = 1; v.jr = 32'h10 * (k + 1);
         drive(v); edge_step(); check_vec(v);
         chk("call.ras_empty", 32'(bus.o_ras_empty), RAS_EN ? 0 : 1);
      end
      for (int k = 0; k < 5; k++) begin
         v = mk("ret", 0,0,0,0,32'h0, 1,32'h900,
                (RAS_EN && k < 4) ? 32'h50 - 32'h10*k : 32'h900, 1,1);
         v.ret = 1;
         drive(v); edge_step(); check_vec(v);
         chk("ret.ras_empty", 32'(bus.o_ras_empty), (!RAS_EN || k >= 3) ? 1 : 0);
      end

      // Random traffic against the model
      rst_n = 1'b0;
      model_reset();
      drive(idle); edge_step();
      rst_n = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         v = idle;
         v.nm    = "rnd";
         v.stall = ($urandom_range(0, 99) < 30);
         v.halt  = ($urandom_range(0, 99) < 2);
         v.exc   = ($urandom_range(0, 99) < 4);
         v.br    = ($urandom_range(0, 99) < 10);
         v.ba    = $urandom;
         v.jmp   = ($urandom_range(0, 99) < 20);
         v.ja    = $urandom;
         v.call  = ($urandom_range(0, 99) < 35);
         v.ret   = ($urandom_range(0, 99) < 35);
         v.jr    = $urandom;
         do_rst  = ($urandom_range(0, 249) == 0);
         if (do_rst) begin rst_n = 1'b0; model_reset(); end
         else rst_n = 1'b1;
         drive(v);
         edge_step();
         if (!do_rst) model_edge(v);
         chk("rnd.pc", bus.o_pc, m_pc);
         chk("rnd.pc_seq", bus.o_pc_seq, m_pc + INC);
         chk("rnd.valid", 32'(bus.o_valid), 32'(m_valid));
         chk("rnd.redirect", 32'(bus.o_redirect), 32'(m_redir));
         chk("rnd.ras_empty", 32'(bus.o_ras_empty), RAS_EN ? 32'(ras_q.size() == 0) : 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
